trng_collector: RTL

//  Consumer end of the metastable-cell entropy path. Samples the raw bit Y of one

---
 rtl/trng_collector.sv | 132 +++++++++++++
 1 files changed

// File: rtl/trng_collector.sv
// Metastable-cell entropy collector: 2-FF sync, von Neumann debias, word packing, valid/ready read.
// Define TRNG_HEALTH_EN to add the repetition-count health test with output gating.
module trng_collector #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RCT_LIMIT = 32
) (
  input  logic             clk_sampling,
  input  logic             rst,
  input  logic             raw_bit,
  input  logic             en,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             overrun,
  output logic             health_fail
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {PH_FIRST, PH_SECOND} phase_t;

  phase_t           phase_q, phase_d;
  logic             sync1, sync2;
  logic             stored;
  logic [WIDTH-2:0] shift_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ovr_q;
  logic             hf;

  logic             keep;
  logic             word_done;
  logic             slot_free;
  logic             xfer;
  logic [WIDTH-1:0] ext;

  always_comb begin
    phase_d   = PH_FIRST;
    keep      = 1'b0;
    ext       = {shift_q, stored};
    word_done = 1'b0;
    xfer      = rd_valid && rd_ready;
    slot_free = !hf && (!rd_valid || rd_ready);
    if (en) begin
      phase_d = (phase_q == PH_FIRST) ? PH_SECOND : PH_FIRST;
      // 01 keeps 0 and 10 keeps 1, so the kept bit is always the stored first half
      keep    = (phase_q == PH_SECOND) && (stored != sync2);
    end
    word_done = keep && (count_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk_sampling or posedge rst) begin
    if (rst) begin
      phase_q <= PH_FIRST;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_ff @(posedge clk_sampling or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      stored  <= 1'b0;
      shift_q <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1 <= raw_bit;
      sync2 <= sync1;
      if (en && (phase_q == PH_FIRST)) begin
        stored <= sync2;
      end
      if (keep && !word_done) begin
        shift_q <= ext[WIDTH-2:0];
        count_q <= count_q + 1'b1;
      end
      // A load on the same edge as a transfer keeps rd_valid high
      if (word_done && slot_free) begin
        data_q  <= ext;
        valid_q <= 1'b1;
        count_q <= '0;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end
      if (word_done && !slot_free) begin
        ovr_q <= 1'b1;
      end else if (xfer) begin
        ovr_q <= 1'b0;
      end
    end
  end

`ifdef TRNG_HEALTH_EN
  localparam int unsigned RW = $clog2(RCT_LIMIT + 1);

  logic          sync2_prev;
  logic [RW-1:0] run_q;
  logic          hf_q;

  always_ff @(posedge clk_sampling or posedge rst) begin
    if (rst) begin
      sync2_prev <= 1'b0;
      run_q      <= '0;
      hf_q       <= 1'b0;
    end else begin
      sync2_prev <= sync2;
      if (sync2 != sync2_prev) begin
        run_q <= RW'(1);
      end else if (run_q != RW'(RCT_LIMIT)) begin
        run_q <= run_q + 1'b1;
      end
      if (run_q == RW'(RCT_LIMIT)) begin
        hf_q <= 1'b1;
      end
    end
  end

  assign hf = hf_q;
`else
  assign hf = 1'b0;
`endif

  assign rd_data     = data_q;
  assign rd_valid    = valid_q && !hf;
  assign overrun     = ovr_q;
  assign health_fail = hf;

endmodule
